mem_responder: RTL and testbench

Memory-side responder for the multicycle RISC-V core's unified instruction/data bus. It accepts one request at a time, inserts a configurable number of wait states, then commits the write or returns registered read data with a one-cycle `ready` strobe. It also decodes a small MMIO window holding a free-running cycle counter and an 8-bit GPIO output register. It sits between the core's memory port and the on-chip RAM, on the opposite side of the core's `Addr`/`MemWrite`/`WriteData`/`ReadData` interface.

---
 rtl/riscv_mem_pkg.sv | 26 ++
 rtl/mem_responder_if.sv | 17 +
 rtl/mem_responder_array.sv | 31 +++
 rtl/mem_responder.sv | 109 ++++++++++
 tb/tb_mem_responder.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/riscv_mem_pkg.sv
// ---------------------------------------------------------------------------
// riscv_mem_pkg: shared types and constants for the core-side memory responder.
//   mem_state_e    - responder FSM states
//   mem_req_t      - request latched when the responder is IDLE
//   MMIO_*_OFS     - offsets inside the 64 KiB MMIO window
//   MMIO_BASE_DFLT - default MMIO window base
// ---------------------------------------------------------------------------
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  localparam logic [15:0] MMIO_CNT_OFS   = 16'h0000;
  localparam logic [15:0] MMIO_GPIO_OFS  = 16'h0004;
  localparam logic [31:0] MMIO_BASE_DFLT = 32'hFFFF_0000;

endpackage

// File: rtl/mem_responder_if.sv
// ---------------------------------------------------------------------------
// mem_responder_if: core <-> memory request/response bus.
//   req/we/addr/wdata : driven by the core (master)
//   rdata/ready/err   : driven by the responder (slave)
// ---------------------------------------------------------------------------
interface mem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  modport master (output req, we, addr, wdata, input  rdata, ready, err);
  modport slave  (input  req, we, addr, wdata, output rdata, ready, err);
endinterface

// File: rtl/mem_responder_array.sv
// ---------------------------------------------------------------------------
// mem_array: single-port word RAM, synchronous write and synchronous read.
//   i_clk   : clock
//   i_we    : write enable (write i_wdata at i_idx)
//   i_re    : read enable (register word at i_idx into o_rdata)
//   i_idx   : word index
//   i_wdata : write data
//   o_rdata : registered read data, holds until the next read
// Contents are not reset.
// ---------------------------------------------------------------------------
module mem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_idx,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);
  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_idx] <= i_wdata;
    if (i_re) r_q <= r_mem[i_idx];
  end

  assign o_rdata = r_q;
endmodule

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder: one-at-a-time memory responder with wait states, RAM and a
// small MMIO window (free-running cycle counter, 8-bit GPIO register).
//   i_clk      : clock, rising edge
//   i_rst      : asynchronous active-low reset
//   bus        : slave side of mem_responder_if (req/we/addr/wdata in,
//                rdata/ready/err out)
//   o_gpio_out : GPIO output register
// The access is performed on the clock edge that leaves RESP, so ready/err/
// rdata/gpio all change together and are visible the cycle after RESP.
// ---------------------------------------------------------------------------
module mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] MMIO_BASE   = MMIO_BASE_DFLT
) (
  input  logic           i_clk,
  input  logic           i_rst,
  mem_responder_if.slave bus,
  output logic [7:0]     o_gpio_out
);
  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  mem_state_e  r_state, w_next;
  mem_req_t    r_req;
  logic [3:0]  r_wcnt;
  logic [31:0] r_cnt;
  logic [31:0] r_rdata;
  logic [7:0]  r_gpio;
  logic        r_ready, r_err, r_sel_ram;

  logic        w_misal, w_ram_hit, w_mmio_hit, w_cnt_hit, w_gpio_hit, w_fault;
  logic        w_do, w_ram_wr, w_ram_rd;
  logic [31:0] w_ram_q;

  // decode on the latched request
  assign w_misal    = |r_req.addr[1:0];
  assign w_ram_hit  = (r_req.addr[31:AW+2] == '0);
  assign w_mmio_hit = (r_req.addr[31:16] == MMIO_BASE[31:16]);
  assign w_cnt_hit  = w_mmio_hit && (r_req.addr[15:0] == MMIO_CNT_OFS);
  assign w_gpio_hit = w_mmio_hit && (r_req.addr[15:0] == MMIO_GPIO_OFS);
  assign w_fault    = w_misal || !(w_ram_hit || w_cnt_hit || w_gpio_hit);

  assign w_do     = (r_state == RESP);
  assign w_ram_wr = w_do && !w_fault && w_ram_hit &&  r_req.we;
  assign w_ram_rd = w_do && !w_fault && w_ram_hit && !r_req.we;

  mem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_ram_wr),
    .i_re    (w_ram_rd),
    .i_idx   (r_req.addr[AW+1:2]),
    .i_wdata (r_req.wdata),
    .o_rdata (w_ram_q)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.req) w_next = (WAIT_STATES > 0) ? WAIT : RESP;
      WAIT:    if (r_wcnt == '0) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_req     <= '0;
      r_wcnt    <= '0;
      r_cnt     <= '0;
      r_rdata   <= '0;
      r_gpio    <= '0;
      r_ready   <= 1'b0;
      r_err     <= 1'b0;
      r_sel_ram <= 1'b0;
    end else begin
      r_cnt   <= r_cnt + 32'd1;
      r_ready <= 1'b0;
      if (r_state == IDLE && bus.req) begin
        r_req  <= '{we: bus.we, addr: bus.addr, wdata: bus.wdata};
        r_wcnt <= WAIT_LOAD;
      end
      if (r_state == WAIT && r_wcnt != '0) r_wcnt <= r_wcnt - 4'd1;
      if (w_do) begin
        r_ready   <= 1'b1;
        r_err     <= w_fault;
        r_sel_ram <= w_ram_rd;   // RAM word arrives from the array register
        r_rdata   <= '0;
        if (!w_fault && !r_req.we && w_cnt_hit)  r_rdata <= r_cnt;
        if (!w_fault && !r_req.we && w_gpio_hit) r_rdata <= {24'h0, r_gpio};
        if (!w_fault &&  r_req.we && w_gpio_hit) r_gpio  <= r_req.wdata[7:0];
      end
    end
  end

  assign bus.rdata  = r_sel_ram ? w_ram_q : r_rdata;
  assign bus.ready  = r_ready;
  assign bus.err    = r_err;
  assign o_gpio_out = r_gpio;
endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder: directed vector table against a WAIT_STATES=1 instance,
// plus hand sequences for the counter, reset-during-WAIT and back-to-back
// throughput on a WAIT_STATES=0 instance.
// ---------------------------------------------------------------------------
module tb_mem_responder;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] gpio0, gpio1;
  int         total = 0;
  int         bad   = 0;

  mem_responder_if bus0();
  mem_responder_if bus1();

  mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(1)) dut0 (
    .i_clk(clk), .i_rst(rst_n), .bus(bus0), .o_gpio_out(gpio0));
  mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut1 (
    .i_clk(clk), .i_rst(rst_n), .bus(bus1), .o_gpio_out(gpio1));

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [7:0]  exp_gpio;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // called #1 after a posedge; req is sampled at the next edge
  task automatic access(input logic we, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int lat);
    bus0.req = 1'b1; bus0.we = we; bus0.addr = a; bus0.wdata = d;
    @(posedge clk); #1;
    bus0.req = 1'b0;
    lat = 0; rd = '0; er = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus0.ready) begin
        lat = i; rd = bus0.rdata; er = bus0.err;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, c1, c2;
    logic        er;
    int          lat;

    vt[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,          1'b0, 8'h00};
    vt[1]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF,  1'b0, 8'h00};
    vt[2]  = '{1'b0, 32'h0000_0012, 32'h0,         32'h0,          1'b1, 8'h00};
    vt[3]  = '{1'b0, 32'h0000_0400, 32'h0,         32'h0,          1'b1, 8'h00};
    vt[4]  = '{1'b1, 32'h0000_0012, 32'hFFFF_FFFF, 32'h0,          1'b1, 8'h00};
    vt[5]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF,  1'b0, 8'h00};
    vt[6]  = '{1'b1, 32'hFFFF_0004, 32'h0000_01A5, 32'h0,          1'b0, 8'hA5};
    vt[7]  = '{1'b0, 32'hFFFF_0004, 32'h0,         32'h0000_00A5,  1'b0, 8'hA5};
    vt[8]  = '{1'b0, 32'hFFFF_0008, 32'h0,         32'h0,          1'b1, 8'hA5};
    vt[9]  = '{1'b1, 32'h0000_03FC, 32'h0BAD_F00D, 32'h0,          1'b0, 8'hA5};
    vt[10] = '{1'b0, 32'h0000_03FC, 32'h0,         32'h0BAD_F00D,  1'b0, 8'hA5};
    vt[11] = '{1'b0, 32'hFFFE_0004, 32'h0,         32'h0,          1'b1, 8'hA5};
    vt[12] = '{1'b1, 32'h0000_0020, 32'hCAFE_F00D, 32'h0,          1'b0, 8'hA5};
    vt[13] = '{1'b0, 32'h0000_0020, 32'h0,         32'hCAFE_F00D,  1'b0, 8'hA5};

    rst_n = 1'b0;
    bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = '0; bus0.wdata = '0;
    bus1.req = 1'b0; bus1.we = 1'b0; bus1.addr = '0; bus1.wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'h0, bus0.ready}, 32'h0);
    chk("rst_err",   {31'h0, bus0.err},   32'h0);
    chk("rst_rdata", bus0.rdata,          32'h0);
    chk("rst_gpio",  {24'h0, gpio0},      32'h0);
    chk("rst_ready1",{31'h0, bus1.ready}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      access(vt[i].we, vt[i].addr, vt[i].wdata, rd, er, lat);
      chk($sformatf("v%0d_latency", i), lat, 2);
      chk($sformatf("v%0d_err", i), {31'h0, er}, {31'h0, vt[i].exp_err});
      if (!vt[i].we) chk($sformatf("v%0d_rdata", i), rd, vt[i].exp_rd);
      chk($sformatf("v%0d_gpio", i), {24'h0, gpio0}, {24'h0, vt[i].exp_gpio});
      @(posedge clk); #1;
      chk($sformatf("v%0d_ready_1cyc", i), {31'h0, bus0.ready}, 32'h0);
    end

    // counter: reads sampled 10 edges apart with a counter write in between
    c1 = '0; c2 = '0;
    bus0.req = 1'b1; bus0.we = 1'b0; bus0.addr = 32'hFFFF_0000;
    @(posedge clk); #1;
    bus0.req = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      case (i)
        2: begin
          chk("cnt_rd1_ready", {31'h0, bus0.ready}, 32'h1);
          chk("cnt_rd1_err",   {31'h0, bus0.err},   32'h0);
          c1 = bus0.rdata;
        end
        3: begin bus0.req = 1'b1; bus0.we = 1'b1; bus0.addr = 32'hFFFF_0000; bus0.wdata = 32'h55; end
        4: bus0.req = 1'b0;
        6: begin
          chk("cnt_wr_ready", {31'h0, bus0.ready}, 32'h1);
          chk("cnt_wr_err",   {31'h0, bus0.err},   32'h0);
        end
        9: begin bus0.req = 1'b1; bus0.we = 1'b0; bus0.addr = 32'hFFFF_0000; end
        10: bus0.req = 1'b0;
        12: begin
          chk("cnt_rd2_ready", {31'h0, bus0.ready}, 32'h1);
          c2 = bus0.rdata;
        end
        default: ;
      endcase
    end
    chk("cnt_delta", c2 - c1, 32'd10);

    // reset while a write sits in WAIT
    access(1'b0, 32'h20, 32'h0, rd, er, lat);
    chk("pre_rst_rdata", rd, 32'hCAFE_F00D);
    @(posedge clk); #1;
    bus0.req = 1'b1; bus0.we = 1'b1; bus0.addr = 32'h20; bus0.wdata = 32'h1234_5678;
    @(posedge clk); #1;
    bus0.req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", {31'h0, bus0.ready}, 32'h0);
    chk("midrst_err",   {31'h0, bus0.err},   32'h0);
    chk("midrst_rdata", bus0.rdata,          32'h0);
    chk("midrst_gpio",  {24'h0, gpio0},      32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    access(1'b0, 32'h20, 32'h0, rd, er, lat);
    chk("postrst_latency", lat, 2);
    chk("postrst_rdata",   rd, 32'hCAFE_F00D);
    chk("postrst_err",     {31'h0, er}, 32'h0);
    @(posedge clk); #1;

    // zero wait states, req held high: ready on every second cycle
    bus1.req = 1'b1; bus1.we = 1'b0; bus1.addr = 32'h0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      chk($sformatf("tput_ready_%0d", i), {31'h0, bus1.ready}, (i % 2 == 0) ? 32'h1 : 32'h0);
      if (bus1.ready) chk($sformatf("tput_err_%0d", i), {31'h0, bus1.err}, 32'h0);
    end
    bus1.req = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
